wen_decoder_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 2:4 write-enable decoder.
- Decodes an SEL_W-bit destination-register index into a 2^SEL_W one-hot write-enable vector.
- Carries the vector through LATENCY pipeline stages, aligned with the CPU's writeback stage, and supports stall and flush.
- Exposes a busy vector (OR of all in-flight one-hots) that the hazard/forwarding logic uses to detect pending writes.

---
 rtl/wen_decoder_pipe.sv | 129 ++++++++++++
 tb/tb_wen_decoder_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wen_decoder_pipe.sv
// -----------------------------------------------------------------------------
// wen_decoder_pipe
//
// Pipelined, parametrised write-enable decoder. A destination-register index
// (sel) is decoded into a one-hot write-enable vector. That vector is carried
// through LATENCY register stages so that it lines up with the CPU writeback
// stage. The pipeline supports stall (freeze every stage) and flush (squash
// every stage except the last one).
//
// Ports:
//   clk      in   1        rising-edge clock
//   reset    in   1        asynchronous, active-high reset (clears all stages)
//   sel      in   SEL_W    destination register index
//   en       in   1        write request; 0 inserts a bubble
//   stall    in   1        hold every stage
//   flush    in   1        clear all stages except the last
//   o        out  N        one-hot write enable from the last stage
//   o_valid  out  1        OR-reduction of o
//   busy     out  N        OR of every stage vector (pending writes)
//
// Parameters:
//   SEL_W     register index width; N = 2**SEL_W output bits
//   LATENCY   number of stages from sel capture to o (1..8)
//   MSB_FIRST 1 = legacy ordering (sel=0 drives o[N-1]); 0 = natural ordering
//   ZERO_REG  index of the hard-wired zero register
//
// Optional feature:
//   WEN_DECODER_ZERO_SUPPRESS_EN - when defined, a request whose raw sel
//   equals ZERO_REG is decoded as a bubble. The comparison is made before the
//   MSB_FIRST remap. The suppressed write never shows up on o or on busy.
// -----------------------------------------------------------------------------
module wen_decoder_pipe #(
  parameter int SEL_W     = 5,
  parameter int LATENCY   = 3,
  parameter int MSB_FIRST = 0,
  parameter int ZERO_REG  = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  input  logic                  stall,
  input  logic                  flush,
  output logic [2**SEL_W-1:0]   o,
  output logic                  o_valid,
  output logic [2**SEL_W-1:0]   busy
);

  localparam int N = 2**SEL_W;
  localparam logic [N-1:0]     ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] ZERO_IDX = SEL_W'(ZERO_REG);

`ifdef WEN_DECODER_ZERO_SUPPRESS_EN
  localparam bit ZERO_SUPPRESS = 1'b1;
`else
  localparam bit ZERO_SUPPRESS = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Decode. N-1-sel equals ~sel at SEL_W bits because N-1 is all ones.
  // The zero-register match uses raw sel, before the ordering remap.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] idx;
  logic [N-1:0]     d;

  always_comb begin
    idx = (MSB_FIRST != 0) ? ~sel : sel;
    d   = '0;
    if (en && !(ZERO_SUPPRESS && (sel == ZERO_IDX))) begin
      d = ONE << idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers. stage_q[k] is the output of stage k.
  // busy_acc is a running OR across the stages, so busy = busy_acc[LATENCY].
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0][N-1:0] stage_q;
  logic [LATENCY:0][N-1:0]   busy_acc;

  assign busy_acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic [N-1:0] stage_in;
      logic [N-1:0] s_reg;

      if (gi == 0) begin : g_first_in
        assign stage_in = d;
      end else begin : g_chain_in
        assign stage_in = stage_q[gi-1];
      end

      if (gi < LATENCY - 1) begin : g_mid
        // Squashable stage. Flush takes priority over stall, so a
        // wrong-path write is killed even while the pipe is frozen.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            s_reg <= '0;
          end else if (flush) begin
            s_reg <= '0;
          end else if (!stall) begin
            s_reg <= stage_in;
          end
        end
      end else begin : g_last
        // Last stage. The write already past the flush point still commits.
        // Only in the single-stage pipe does flush discard the incoming d,
        // because that d is this stage's own input.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            s_reg <= '0;
          end else if (!stall) begin
            s_reg <= (LATENCY == 1 && flush) ? '0 : stage_in;
          end
        end
      end

      assign stage_q[gi]    = s_reg;
      assign busy_acc[gi+1] = busy_acc[gi] | s_reg;
    end
  endgenerate

  assign o       = stage_q[LATENCY-1];
  assign o_valid = |stage_q[LATENCY-1];
  assign busy    = busy_acc[LATENCY];

endmodule

// File: tb/tb_wen_decoder_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for wen_decoder_pipe.
// Instance a uses the defaults: SEL_W=5, LATENCY=3, MSB_FIRST=0.
// Instance b uses the legacy ordering: SEL_W=2, LATENCY=1, MSB_FIRST=1.
// Each scenario is a task with its own inline checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wen_decoder_pipe;

  logic        clk = 1'b0;
  logic        reset;

  logic [4:0]  a_sel;
  logic        a_en, a_stall, a_flush;
  logic [31:0] a_o, a_busy;
  logic        a_o_valid;

  logic [1:0]  b_sel;
  logic        b_en, b_stall, b_flush;
  logic [3:0]  b_o, b_busy;
  logic        b_o_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wen_decoder_pipe #(.SEL_W(5), .LATENCY(3), .MSB_FIRST(0), .ZERO_REG(31)) dut_a (
    .clk(clk), .reset(reset), .sel(a_sel), .en(a_en), .stall(a_stall),
    .flush(a_flush), .o(a_o), .o_valid(a_o_valid), .busy(a_busy)
  );

  wen_decoder_pipe #(.SEL_W(2), .LATENCY(1), .MSB_FIRST(1), .ZERO_REG(3)) dut_b (
    .clk(clk), .reset(reset), .sel(b_sel), .en(b_en), .stall(b_stall),
    .flush(b_flush), .o(b_o), .o_valid(b_o_valid), .busy(b_busy)
  );

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string name, input logic [31:0] exp_o,
                         input logic [31:0] exp_busy);
    tests_run++;
    if (a_o !== exp_o || a_busy !== exp_busy || a_o_valid !== (|exp_o)) begin
      tests_failed++;
      $display("FAIL %s: o=%h busy=%h o_valid=%b, required o=%h busy=%h o_valid=%b",
               name, a_o, a_busy, a_o_valid, exp_o, exp_busy, |exp_o);
    end else begin
      $display("[TB] ok   %s: o=%h busy=%h", name, a_o, a_busy);
    end
  endtask

  task automatic idle_a();
    a_en = 1'b0; a_sel = '0; a_stall = 1'b0; a_flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_a();
    b_en = 1'b0; b_sel = '0; b_stall = 1'b0; b_flush = 1'b0;
    step();
    check_a("reset_state", 32'h0, 32'h0);
    tests_run++;
    if (b_o !== 4'h0 || b_busy !== 4'h0 || b_o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state_b: o=%h busy=%h, required 0", b_o, b_busy);
    end else begin
      $display("[TB] ok   reset_state_b: o=%h busy=%h", b_o, b_busy);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_async_reset();
    // Put three writes in flight (sel 1, 2, 3) and then reset mid-cycle.
    a_en = 1'b1; a_sel = 5'd1; step();
    a_sel = 5'd2; step();
    a_sel = 5'd3; step();
    a_en = 1'b0;
    check_a("inflight_before_reset", 32'h2, 32'hE);
    #2 reset = 1'b1;
    #1 check_a("async_reset_immediate", 32'h0, 32'h0);
    #2 reset = 1'b0;
    a_en = 1'b1; a_sel = 5'd4;
    step();
    a_en = 1'b0;
    check_a("post_reset_edge1", 32'h0, 32'h10);
    step();
    check_a("post_reset_edge2", 32'h0, 32'h10);
    step();
    check_a("post_reset_edge3", 32'h10, 32'h10);
    step();
    check_a("post_reset_drain", 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    a_en = 1'b1; a_sel = 5'd1; step();
    a_sel = 5'd2; step();
    a_sel = 5'd3; step();
    a_en = 1'b0;
    check_a("b2b_o_sel1", 32'h2, 32'hE);
    step();
    check_a("b2b_o_sel2", 32'h4, 32'hC);
    step();
    check_a("b2b_o_sel3", 32'h8, 32'h8);
    step();
    check_a("b2b_bubble", 32'h0, 32'h0);
  endtask

  task automatic test_stall();
    a_en = 1'b1; a_sel = 5'd7; step();
    a_en = 1'b0; step();
    check_a("stall_pre", 32'h0, 32'h80);
    a_stall = 1'b1; a_en = 1'b1; a_sel = 5'd12;
    for (int i = 0; i < 4; i++) begin
      step();
      check_a($sformatf("stall_hold%0d", i), 32'h0, 32'h80);
    end
    a_stall = 1'b0; a_en = 1'b0;
    step();
    check_a("stall_resume", 32'h80, 32'h80);
    step();
    check_a("stall_drain", 32'h0, 32'h0);
  endtask

  task automatic load_569();
    a_en = 1'b1; a_sel = 5'd5; step();
    a_sel = 5'd6; step();
    a_sel = 5'd9; step();
    a_en = 1'b0;
  endtask

  task automatic test_flush();
    load_569();
    check_a("flush_loaded", 32'h20, 32'h260);
    a_flush = 1'b1; a_en = 1'b1; a_sel = 5'd10;
    step();
    a_flush = 1'b0; a_en = 1'b0;
    check_a("flush_commit_sel6", 32'h40, 32'h40);
    step();
    check_a("flush_after", 32'h0, 32'h0);

    load_569();
    a_flush = 1'b1; a_stall = 1'b1; a_en = 1'b1; a_sel = 5'd10;
    step();
    a_flush = 1'b0; a_stall = 1'b0; a_en = 1'b0;
    check_a("flush_stall_hold", 32'h20, 32'h20);
    step();
    check_a("flush_stall_after", 32'h0, 32'h0);
  endtask

  task automatic test_msb_first();
    logic [3:0] exp_tab [4];
    exp_tab[0] = 4'b1000; exp_tab[1] = 4'b0100;
    exp_tab[2] = 4'b0010; exp_tab[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      b_en = 1'b1; b_sel = 2'(k);
      step();
      tests_run++;
      if (b_o !== exp_tab[k] || b_busy !== exp_tab[k] || b_o_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL msb_first_sel%0d: o=%b busy=%b, required %b", k, b_o, b_busy, exp_tab[k]);
      end else begin
        $display("[TB] ok   msb_first_sel%0d: o=%b", k, b_o);
      end
    end
    b_en = 1'b0;
    step();
    tests_run++;
    if (b_o !== 4'b0000 || b_o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL msb_first_bubble: o=%b, required 0000", b_o);
    end else begin
      $display("[TB] ok   msb_first_bubble: o=%b", b_o);
    end
    // In a single-stage pipe, flush discards the incoming request.
    b_en = 1'b1; b_sel = 2'd2; b_flush = 1'b1;
    step();
    b_en = 1'b0; b_flush = 1'b0;
    tests_run++;
    if (b_o !== 4'b0000) begin
      tests_failed++;
      $display("FAIL lat1_flush: o=%b, required 0000", b_o);
    end else begin
      $display("[TB] ok   lat1_flush: o=%b", b_o);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] exp_o, exp_busy;
    a_en = 1'b1; a_sel = 5'd31;
    for (int i = 1; i <= 4; i++) begin
      step();
      a_en = 1'b0;
`ifdef WEN_DECODER_ZERO_SUPPRESS_EN
      exp_o = 32'h0; exp_busy = 32'h0;
`else
      exp_o    = (i == 3) ? 32'h8000_0000 : 32'h0;
      exp_busy = (i <= 3) ? 32'h8000_0000 : 32'h0;
`endif
      check_a($sformatf("zero_reg_edge%0d", i), exp_o, exp_busy);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_msb_first();
    test_zero_reg();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
